// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: one shared period counter, per-channel duty registers
// stepped by two debounced buttons, edge/center alignment, updates applied at period start.
module pwm_multi_ctrl #(
   parameter  int CHANNELS  = 4,
   parameter  int CNT_W     = 8,
   parameter  int PERIOD    = 10,
   parameter  int DUTY_INIT = 5,
   parameter  int DEB_DIV   = 2,
   localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                btn_inc,
   input  logic                btn_dec,
   input  logic [SEL_W-1:0]    ch_sel,
   input  logic                center_mode,
   output logic [CHANNELS-1:0] pwm_out,
   output logic [CNT_W-1:0]    duty_rd
);

   localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DEB_DIV - 1);
   localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] TOP_C     = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] DUTY_C    = CNT_W'(DUTY_INIT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic [DIV_W-1:0]    div_q, div_d;
   logic [1:0]          s1_q, s1_d, s2_q, s2_d;
   logic                tick, inc_pulse, dec_pulse;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                down_q, down_d;
   logic                mode_q, mode_d;
   logic [CNT_W-1:0]    shadow_q [CHANNELS];
   logic [CNT_W-1:0]    shadow_d [CHANNELS];
   logic [CNT_W-1:0]    active_q [CHANNELS];
   logic [CNT_W-1:0]    active_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                boundary, sel_ok;

   // Button path: bit 0 = inc, bit 1 = dec. s1 also acts as the synchronizer stage.
   always_comb begin
      tick      = (div_q == DIV_LAST);
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      s1_d      = s1_q;
      s2_d      = s2_q;
      if (tick) begin
         s1_d = {btn_dec, btn_inc};
         s2_d = s1_q;
      end
      inc_pulse = s1_q[0] & ~s2_q[0] & tick;
      dec_pulse = s1_q[1] & ~s2_q[1] & tick;
   end

   always_comb begin
      sel_ok   = (int'(ch_sel) < CHANNELS);
      shadow_d = shadow_q;
      duty_rd  = '0;
      if (sel_ok) begin
         duty_rd = shadow_q[ch_sel];
         if (inc_pulse && !dec_pulse) begin
            if (shadow_q[ch_sel] < PERIOD_C) shadow_d[ch_sel] = shadow_q[ch_sel] + ONE_C;
         end else if (dec_pulse && !inc_pulse) begin
            if (shadow_q[ch_sel] != '0) shadow_d[ch_sel] = shadow_q[ch_sel] - ONE_C;
         end
      end
   end

   // Counter, mode and duty transfer. A new period always begins at cnt=0 counting up,
   // so loading the new mode there needs no counter restart beyond forcing direction up.
   always_comb begin
      boundary = ena & (cnt_q == '0);
      cnt_d    = cnt_q;
      down_d   = down_q;
      mode_d   = mode_q;
      active_d = active_q;
      if (boundary) begin
         mode_d   = center_mode;
         active_d = shadow_q;
      end
      if (ena) begin
         if (!mode_d) begin
            down_d = 1'b0;
            cnt_d  = (cnt_q == TOP_C) ? '0 : cnt_q + ONE_C;
         end else if (!down_q || boundary) begin
            down_d = 1'b0;
            if (cnt_q == TOP_C) begin
               if (PERIOD == 2) begin
                  cnt_d = '0;
               end else begin
                  cnt_d  = TOP_C - ONE_C;
                  down_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + ONE_C;
            end
         end else begin
            if (cnt_q == ONE_C) begin
               cnt_d  = '0;
               down_d = 1'b0;
            end else begin
               cnt_d = cnt_q - ONE_C;
            end
         end
      end
   end

   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = ena & (cnt_q < active_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q  <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         cnt_q  <= '0;
         down_q <= 1'b0;
         mode_q <= 1'b0;
         pwm_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= DUTY_C;
            active_q[i] <= DUTY_C;
         end
      end else begin
         div_q    <= div_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         cnt_q    <= cnt_d;
         down_q   <= down_d;
         mode_q   <= mode_d;
         pwm_q    <= pwm_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl (CHANNELS=4, PERIOD=10, DUTY_INIT=5, DEB_DIV=1).
module tb_pwm_multi_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_dec = 1'b0;
   logic [1:0] ch_sel = 2'd0;
   logic       center_mode = 1'b0;
   logic [3:0] pwm_out;
   logic [7:0] duty_rd;

   int vectors = 0;
   int miscompares = 0;
   // Expected counter position (value the DUT compares at the next edge), direction, mode.
   int ph = 0;
   bit dn = 1'b0;
   bit mode = 1'b0;

   pwm_multi_ctrl #(
      .CHANNELS(4), .CNT_W(8), .PERIOD(10), .DUTY_INIT(5), .DEB_DIV(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .ch_sel(ch_sel), .center_mode(center_mode), .pwm_out(pwm_out), .duty_rd(duty_rd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst_n) begin
         ph = 0; dn = 1'b0; mode = 1'b0;
      end else if (ena) begin
         if (ph == 0) mode = center_mode;
         if (!mode) begin
            ph = (ph == 9) ? 0 : ph + 1; dn = 1'b0;
         end else if (!dn) begin
            if (ph == 9) begin ph = 8; dn = 1'b1; end else ph = ph + 1;
         end else begin
            if (ph == 1) begin ph = 0; dn = 1'b0; end else ph = ph - 1;
         end
      end
   endtask

   task automatic chk_pwm(input logic [3:0] exp, input string tag);
      vectors++;
      assert (pwm_out === exp) else begin
         miscompares++;
         $error("FAIL %s: observed pwm_out=%b expected %b", tag, pwm_out, exp);
      end
   endtask

   task automatic chk_duty(input logic [7:0] exp, input string tag);
      vectors++;
      assert (duty_rd === exp) else begin
         miscompares++;
         $error("FAIL %s: observed duty_rd=%0d expected %0d", tag, duty_rd, exp);
      end
   endtask

   task automatic run_chk(input int n, input int d0, input int d1, input int d2, input int d3,
                          input string tag);
      int d[4];
      logic [3:0] e;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) e[k] = rst_n & ena & (ph < d[k]);
         tick();
         chk_pwm(e, tag);
      end
   endtask

   task automatic press(input bit inc, input bit dec, input int hold);
      btn_inc = inc; btn_dec = dec;
      repeat (hold) tick();
      btn_inc = 1'b0; btn_dec = 1'b0;
      tick(); tick();
   endtask

   task automatic sync(input int target);
      int g;
      g = 0;
      while (!(ph == target && !dn) && g < 40) begin
         tick();
         g++;
      end
      if (g >= 40) begin
         vectors++;
         miscompares++;
         $error("FAIL sync: counter position %0d never reached", target);
      end
   endtask

   initial begin
      int hi;
      // Reset state
      ena = 1'b1;
      repeat (3) tick();
      chk_pwm(4'b0000, "reset_pwm");
      chk_duty(8'd5, "reset_duty");
      rst_n = 1'b1;
      run_chk(20, 5, 5, 5, 5, "default_5of10");

      // Held inc on channel 2 gives exactly one step
      ch_sel = 2'd2;
      press(1'b1, 1'b0, 6);
      chk_duty(8'd6, "inc_ch2_once");
      ch_sel = 2'd1; #1;
      chk_duty(8'd5, "ch1_untouched");
      sync(0);
      run_chk(10, 5, 5, 6, 5, "ch2_6of10");

      // Saturation on channel 0
      ch_sel = 2'd0;
      repeat (7) press(1'b1, 1'b0, 2);
      chk_duty(8'd10, "sat_high");
      sync(0);
      repeat (10) tick();
      run_chk(10, 10, 5, 6, 5, "ch0_const1");
      repeat (12) press(1'b0, 1'b1, 2);
      chk_duty(8'd0, "sat_low");
      sync(0);
      repeat (10) tick();
      run_chk(10, 0, 5, 6, 5, "ch0_const0");

      // Simultaneous inc+dec is ignored
      ch_sel = 2'd1;
      press(1'b1, 1'b1, 2);
      chk_duty(8'd5, "inc_dec_cancel");

      // Mid-period press at cnt=4 takes effect only at the next period
      sync(4);
      btn_inc = 1'b1;
      run_chk(2, 0, 5, 6, 5, "midperiod_hold");
      btn_inc = 1'b0;
      run_chk(4, 0, 5, 6, 5, "midperiod_rest");
      chk_duty(8'd6, "midperiod_shadow");
      run_chk(10, 0, 6, 6, 5, "midperiod_applied");

      // Center mode requested mid-period, switch at next cnt=0
      sync(3);
      center_mode = 1'b1;
      run_chk(7, 0, 6, 6, 5, "center_pending");
      run_chk(36, 0, 6, 6, 5, "center_18cyc");
      hi = 0;
      for (int i = 0; i < 18; i++) begin
         tick();
         hi += int'(pwm_out[3]);
      end
      vectors++;
      assert (hi == 9) else begin
         miscompares++;
         $error("FAIL center_high_count: observed %0d expected 9", hi);
      end
      run_chk(18, 0, 6, 6, 5, "center_again");

      // ena low for 7 cycles at cnt=3
      sync(3);
      ena = 1'b0;
      run_chk(7, 0, 6, 6, 5, "ena_low");
      ena = 1'b1;
      run_chk(18, 0, 6, 6, 5, "ena_resume");

      // Reset mid-period with a pending shadow value of 8
      ch_sel = 2'd2;
      sync(2);
      press(1'b1, 1'b0, 2);
      press(1'b1, 1'b0, 2);
      chk_duty(8'd8, "pending_8");
      rst_n = 1'b0;
      center_mode = 1'b0;
      run_chk(2, 0, 0, 0, 0, "in_reset");
      for (int k = 0; k < 4; k++) begin
         ch_sel = 2'(k); #1;
         chk_duty(8'd5, "reset_restore");
      end
      rst_n = 1'b1;
      run_chk(20, 5, 5, 5, 5, "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
